// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared lock-state and port-id definitions for the RAM port arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } lock_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-port arbiter in front of a single-port synchronous RAM
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    lock_state_t           r_state;
    lock_state_t           w_state_nxt;
    logic                  r_prio;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_rd_pend;
    logic                  r_rd_port;

    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_beat;
    logic                  w_port;
    logic                  w_we;
    logic                  w_lock;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Grant is forced off while reset is held so no beat can leak out during reset.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (rst_n) begin
            case (r_state)
                LOCK_A: w_grant_a = a_valid;
                LOCK_B: w_grant_b = b_valid;
                default: begin
                    if (a_valid && b_valid) begin
                        w_grant_a = (r_prio == PORT_A);
                        w_grant_b = (r_prio == PORT_B);
                    end else begin
                        w_grant_a = a_valid;
                        w_grant_b = b_valid;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_beat  = w_grant_a | w_grant_b;
        w_port  = w_grant_b ? PORT_B : PORT_A;
        w_we    = w_grant_b ? b_we    : a_we;
        w_lock  = w_grant_b ? b_lock  : a_lock;
        w_addr  = w_grant_b ? b_addr  : a_addr;
        w_wdata = w_grant_b ? b_wdata : a_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock state only moves on a beat; an idle locked port keeps the other side stalled.
    always_comb begin
        w_state_nxt = r_state;
        if (w_beat) begin
            if (w_lock) begin
                w_state_nxt = (w_port == PORT_A) ? LOCK_A : LOCK_B;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        a_ready  = w_grant_a;
        b_ready  = w_grant_b;
        ram_we   = w_beat & w_we;
        ram_addr = w_beat ? w_addr : r_last_addr;
        ram_din  = w_wdata;
        a_rvalid = r_rd_pend & (r_rd_port == PORT_A);
        b_rvalid = r_rd_pend & (r_rd_port == PORT_B);
        a_rdata  = ram_dout;
        b_rdata  = ram_dout;
    end

    // Holding the address when idle keeps the RAM's registered address, and thus dout, stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio      <= PORT_A;
            r_last_addr <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_port   <= PORT_A;
        end else begin
            r_rd_pend <= w_beat & ~w_we;
            if (w_beat) begin
                r_prio      <= ~w_port;
                r_last_addr <= w_addr;
                r_rd_port   <= w_port;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with behavioural RAM and reference model
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, a_we, a_lock, a_rvalid;
    logic [11:0] a_addr;
    logic [7:0]  a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_lock, b_rvalid;
    logic [11:0] b_addr;
    logic [7:0]  b_wdata, b_rdata;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_lock(a_lock),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_lock(b_lock),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM, registered address, write-first on the registered address.
    logic [7:0]  ram_mem [0:4095];
    logic [11:0] ram_raddr;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_raddr <= ram_addr;
    end
    assign ram_dout = ram_mem[ram_raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, lock owner (-1 none), priority, pending response.
    logic [7:0]  m_mem [0:4095];
    int          m_lock;
    int          m_prio;
    logic [11:0] m_last_addr;
    bit          m_rsp_valid;
    int          m_rsp_port;
    logic [7:0]  m_rsp_data;

    always @(negedge clk) begin
        bit          ga, gb;
        bit          we, lk;
        logic [11:0] ad;
        logic [7:0]  wd;
        int          p;
        if (!rst_n) begin
            check("rst_a_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_a_rvalid", a_rvalid, 0);
            check("rst_b_rvalid", b_rvalid, 0);
            m_lock = -1; m_prio = 0; m_last_addr = '0; m_rsp_valid = 0;
        end else begin
            check("m_a_rvalid", a_rvalid, (m_rsp_valid && m_rsp_port == 0) ? 1 : 0);
            check("m_b_rvalid", b_rvalid, (m_rsp_valid && m_rsp_port == 1) ? 1 : 0);
            if (m_rsp_valid && m_rsp_port == 0) check("m_a_rdata", a_rdata, m_rsp_data);
            if (m_rsp_valid && m_rsp_port == 1) check("m_b_rdata", b_rdata, m_rsp_data);
            ga = 0; gb = 0;
            if (m_lock == 0)      ga = a_valid;
            else if (m_lock == 1) gb = b_valid;
            else if (a_valid && b_valid) begin
                if (m_prio == 0) ga = 1; else gb = 1;
            end else begin
                ga = a_valid; gb = b_valid;
            end
            p  = gb ? 1 : 0;
            we = gb ? b_we : a_we;
            lk = gb ? b_lock : a_lock;
            ad = gb ? b_addr : a_addr;
            wd = gb ? b_wdata : a_wdata;
            check("m_a_ready", a_ready, ga);
            check("m_b_ready", b_ready, gb);
            check("m_ram_we", ram_we, (ga || gb) && we);
            check("m_ram_addr", ram_addr, (ga || gb) ? ad : m_last_addr);
            if ((ga || gb) && we) check("m_ram_din", ram_din, wd);
            m_rsp_valid = 0;
            if (ga || gb) begin
                if (we) m_mem[ad] = wd;
                else begin
                    m_rsp_valid = 1; m_rsp_port = p; m_rsp_data = m_mem[ad];
                end
                m_prio      = 1 - p;
                m_lock      = lk ? p : -1;
                m_last_addr = ad;
            end
        end
    end

    task automatic drive(input logic av, input logic awe, input logic alk, input logic [11:0] aad,
                         input logic [7:0] awd, input logic bv, input logic bwe, input logic blk,
                         input logic [11:0] bad, input logic [7:0] bwd);
        a_valid = av; a_we = awe; a_lock = alk; a_addr = aad; a_wdata = awd;
        b_valid = bv; b_we = bwe; b_lock = blk; b_addr = bad; b_wdata = bwd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 12'h0, 8'h0, 0, 0, 0, 12'h0, 8'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = 8'h00;
            m_mem[i]   = 8'h00;
        end
        ram_raddr = '0;
        m_lock = -1; m_prio = 0; m_last_addr = '0; m_rsp_valid = 0;
        m_rsp_port = 0; m_rsp_data = '0;

        // Reset held with both requesters asking
        rst_n = 1'b0;
        drive(1, 1, 0, 12'h123, 8'hAA, 1, 1, 0, 12'h456, 8'hBB);
        step();
        check("t1_a_ready", a_ready, 0);
        check("t1_b_ready", b_ready, 0);
        check("t1_ram_we", ram_we, 0);
        step(); step();
        rst_n = 1'b1;
        idle();
        step();

        // Write then read back on port A
        drive(1, 1, 0, 12'h010, 8'h5A, 0, 0, 0, 12'h0, 8'h0);
        check("t2_wr_ready", a_ready, 1);
        check("t2_wr_we", ram_we, 1);
        step();
        drive(1, 0, 0, 12'h010, 8'h00, 0, 0, 0, 12'h0, 8'h0);
        step();
        idle();
        check("t2_a_rvalid", a_rvalid, 1);
        check("t2_a_rdata", a_rdata, 8'h5A);
        check("t2_b_rvalid", b_rvalid, 0);
        step();

        // Both ports reading every cycle alternate A,B,A,B
        drive(1, 1, 0, 12'h001, 8'h11, 0, 0, 0, 12'h0, 8'h0);
        step();
        drive(0, 0, 0, 12'h0, 8'h0, 1, 1, 0, 12'h002, 8'h22);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 12'h001, 8'h0, 1, 0, 0, 12'h002, 8'h0);
            check("t3_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
            check("t3_b_ready", b_ready, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) check("t3_a_rdata", a_rdata, 8'h11);
            if (k == 2)     check("t3_b_rdata", b_rdata, 8'h22);
            step();
        end
        idle();
        check("t3_b_rvalid_last", b_rvalid, 1);
        check("t3_b_rdata_last", b_rdata, 8'h22);
        step();

        // Lock on A stalls B until A releases
        drive(1, 0, 1, 12'h001, 8'h0, 1, 0, 0, 12'h002, 8'h0);
        check("t4_lock_beat", a_ready, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 12'h0, 8'h0, 1, 0, 0, 12'h002, 8'h0);
            check("t4_b_stalled", b_ready, 0);
            step();
        end
        drive(1, 1, 0, 12'h003, 8'h44, 1, 0, 0, 12'h002, 8'h0);
        check("t4_unlock_a", a_ready, 1);
        check("t4_unlock_b", b_ready, 0);
        step();
        drive(0, 0, 0, 12'h0, 8'h0, 1, 0, 0, 12'h002, 8'h0);
        check("t4_b_after", b_ready, 1);
        step();

        // Reset during a pending B read with B locked
        drive(0, 0, 0, 12'h0, 8'h0, 1, 0, 1, 12'h002, 8'h0);
        check("t5_b_beat", b_ready, 1);
        step();
        idle();
        check("t5_b_rvalid_pre", b_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_b_rvalid_drop", b_rvalid, 0);
        step(); step();
        rst_n = 1'b1;
        drive(1, 0, 0, 12'h001, 8'h0, 1, 0, 0, 12'h002, 8'h0);
        check("t5_prio_a", a_ready, 1);
        check("t5_no_lock_b", b_ready, 0);
        step();
        drive(0, 0, 0, 12'h0, 8'h0, 1, 0, 0, 12'h002, 8'h0);
        check("t5_b_free", b_ready, 1);
        step();

        // Address extremes
        drive(1, 1, 0, 12'h000, 8'h3C, 0, 0, 0, 12'h0, 8'h0);
        step();
        drive(0, 0, 0, 12'h0, 8'h0, 1, 1, 0, 12'hFFF, 8'hFF);
        check("t6_max_addr", ram_addr, 12'hFFF);
        step();
        drive(1, 0, 0, 12'hFFF, 8'h0, 0, 0, 0, 12'h0, 8'h0);
        step();
        drive(0, 0, 0, 12'h0, 8'h0, 1, 0, 0, 12'h000, 8'h0);
        check("t6_a_rvalid", a_rvalid, 1);
        check("t6_a_rdata", a_rdata, 8'hFF);
        step();
        idle();
        check("t6_b_rvalid", b_rvalid, 1);
        check("t6_b_rdata", b_rdata, 8'h3C);
        check("t6_idle_addr", ram_addr, 12'h000);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
